sd_crc_engine: RTL and testbench
================================

SD_CRC_ENGINE -- requirements
Module: sd_crc_engine

Interface
REQ-001 Parameter CRC_W, default 7, CRC register width in bits (legal values 7 and 16).
REQ-002 Parameter POLY, default 7'h09, generator polynomial without its implicit x^CRC_W term (16'h1021 for CRC16).
REQ-003 Parameter LANES, default 1, number of independent bit lanes (legal values 1 to 4).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; every state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous zeroing of all lane CRCs; aborts shift-out.
REQ-008 enable  input  1  accumulates in_bits into each lane.
REQ-009 in_bits  input  LANES  one serial bit per lane; bit i goes to lane i.
REQ-010 start_out  input  1  single-cycle request to emit the CRCs serially.
REQ-011 crc  output  LANES*CRC_W  lane CRC registers; lane i occupies bits [i*CRC_W +: CRC_W].
REQ-012 out_bits  output  LANES  current output bit per lane; equals the MSB of each lane register.
REQ-013 out_valid  output  1  out_bits is valid in this cycle.
REQ-014 out_last  output  1  final output bit, asserted together with out_valid.
REQ-015 busy  output  1  high while in the SHIFT state.
REQ-016 crc_ok  output  1  high when every lane register is zero.

Function
REQ-017 There SHALL be two states: ACCUM (the reset state) and SHIFT.
REQ-018 In ACCUM with enable=1, each lane SHALL update fb=in_bit^crc[W-1]; crc<={crc[W-2:0],0}^(fb?POLY:0).
REQ-019 In ACCUM with enable=0, the lane registers SHALL hold their value.
REQ-020 With CRC_W=7, POLY=7'h09 and LANES=1, the block SHALL be bit-exact with the existing single-lane CRC7.
REQ-021 clear SHALL have top priority: all lanes go to zero and the state goes to ACCUM next cycle, regardless of enable or start_out.
REQ-022 In ACCUM, start_out=1 (without clear) SHALL move the state to SHIFT, load the bit counter with CRC_W-1, and ignore enable in that cycle.
REQ-023 In SHIFT, out_valid SHALL be 1 and out_bits SHALL be each lane's crc[W-1].
REQ-024 In SHIFT, each lane SHALL shift left one bit per cycle with zero fill, and the counter SHALL decrement.
REQ-025 out_last SHALL be asserted when the counter is 0; the state returns to ACCUM on the next edge.
REQ-026 A shift-out SHALL emit exactly CRC_W bits, MSB first, and leave every lane register at zero.
REQ-027 In SHIFT, enable and start_out SHALL be ignored.
REQ-028 start_out in the same cycle as the first ACCUM cycle after SHIFT SHALL be accepted and begin a new shift-out.
REQ-029 crc_ok SHALL be combinational: the AND over lanes of (lane register == 0).
REQ-030 For check mode, the user accumulates payload plus received CRC bits; crc_ok=1 then indicates a match.
REQ-031 The counter SHALL be $clog2(CRC_W) bits wide and SHALL never wrap below 0.

Reset
REQ-032 On reset_n=0 the block SHALL asynchronously enter ACCUM with all lane registers at 0, counter 0, out_valid=0, out_last=0 and busy=0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the shift with no further out_valid.
REQ-034 After reset, crc_ok SHALL read 1 and out_bits SHALL read all zeros.

Structure
REQ-035 The polynomial localparams (CRC7 = 7'h09, CRC16 = 16'h1021) SHALL live in a shared sd_defs include file, also used by the SD host.
REQ-036 The per-lane register and update logic SHALL be a sub-module, sd_crc_lane, instantiated LANES times.
REQ-037 The state and counter SHALL live only in sd_crc_engine.

Verification
REQ-038 CRC7, LANES=1: enable over CMD0 bits 40 00 00 00 00 MSB first -> crc=7'h4A; start_out -> 7 bits 1001010 with out_last on the 7th, then crc=0.
REQ-039 CRC7: CMD8 48 00 00 01 AA -> crc=7'h43; then feed 1000011 -> crc_ok=1; a single flipped bit -> crc_ok=0.
REQ-040 CRC16, LANES=4: 512 bytes of 0xFF on every lane (4096 bits per lane) -> each lane crc=16'h7FA1; shift-out -> 16 cycles of out_bits, then crc_ok=1.
REQ-041 clear asserted on the 3rd shift cycle -> out_valid low next cycle, all lanes zero, busy=0.
REQ-042 reset_n pulsed low mid-accumulate and mid-SHIFT -> all outputs at their reset values immediately, without waiting for a clock edge.
REQ-043 start_out held high for 2 cycles with enable=1 throughout -> exactly one 7-bit shift-out, then a second shift-out of zeros only if start_out is high in the first ACCUM cycle.

Source files
------------

// File: rtl/sd_crc_engine_pkg.sv
// Shared SD definitions: CRC generator polynomials (also used by the SD host)
// and the CRC engine state type.
package sd_crc_engine_pkg;

    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;

    typedef enum logic {StAccum, StShift} crc_state_e;

endpackage

// File: rtl/sd_crc_lane.sv
// One CRC lane: MSB-first LFSR accumulate, or plain zero-fill left shift for
// serial emission. clear wins over shift, shift wins over accumulate.
module sd_crc_lane
    import sd_crc_engine_pkg::*;
#(
    parameter int unsigned       CRC_W = 7,
    parameter logic [CRC_W-1:0]  POLY  = SD_CRC7_POLY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             accum_i,
    input  logic             shift_i,
    input  logic             in_bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        fb    = in_bit_i ^ crc_q[CRC_W-1];
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (shift_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
        end else if (accum_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_crc_engine.sv
// Multi-lane SD CRC engine: accumulates one serial bit per lane, then emits
// each lane's CRC MSB first, leaving the lane registers at zero.
module sd_crc_engine
    import sd_crc_engine_pkg::*;
#(
    parameter int unsigned       CRC_W = 7,
    parameter logic [CRC_W-1:0]  POLY  = SD_CRC7_POLY,
    parameter int unsigned       LANES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [LANES-1:0]       in_bits,
    input  logic                   start_out,
    output logic [LANES*CRC_W-1:0] crc,
    output logic [LANES-1:0]       out_bits,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   crc_ok
);

    localparam int unsigned CntW = $clog2(CRC_W);

    crc_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lane_accum, lane_shift;
    logic [LANES-1:0] lane_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StAccum;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = StAccum;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (start_out) begin
                        state_d = StShift;
                        cnt_d   = CntW'(CRC_W - 1);
                    end
                end
                StShift: begin
                    // Counter parks at zero; the last bit returns us to ACCUM.
                    if (cnt_q == '0) begin
                        state_d = StAccum;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_comb begin
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        lane_accum = 1'b0;
        lane_shift = 1'b0;
        case (state_q)
            StAccum: lane_accum = enable && !start_out && !clear;
            StShift: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                out_last   = (cnt_q == '0);
                lane_shift = !clear;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sd_crc_lane #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear_i  (clear),
            .accum_i  (lane_accum),
            .shift_i  (lane_shift),
            .in_bit_i (in_bits[i]),
            .crc_o    (crc[i*CRC_W +: CRC_W])
        );

        assign out_bits[i]  = crc[i*CRC_W + CRC_W - 1];
        assign lane_zero[i] = (crc[i*CRC_W +: CRC_W] == '0);
    end

    assign crc_ok = &lane_zero;

endmodule

// File: tb/tb_sd_crc_engine.sv
// Bench for sd_crc_engine: a CRC7 single-lane and a CRC16 four-lane instance,
// shift-out bits checked by per-instance scoreboard monitors.
module tb_sd_crc_engine;

    typedef struct packed {
        logic [3:0] bits;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    logic       clear7, en7, start7;
    logic [0:0] bits7, out_bits7;
    logic [6:0] crc7;
    logic       out_valid7, out_last7, busy7, crc_ok7;

    logic        clear16, en16, start16;
    logic [3:0]  bits16, out_bits16;
    logic [63:0] crc16;
    logic        out_valid16, out_last16, busy16, crc_ok16;

    exp_t q7[$];
    exp_t q16[$];
    exp_t m7_e, m16_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_crc_engine #(
        .CRC_W (7),
        .POLY  (7'h09),
        .LANES (1)
    ) u7 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear7),
        .enable    (en7),
        .in_bits   (bits7),
        .start_out (start7),
        .crc       (crc7),
        .out_bits  (out_bits7),
        .out_valid (out_valid7),
        .out_last  (out_last7),
        .busy      (busy7),
        .crc_ok    (crc_ok7)
    );

    sd_crc_engine #(
        .CRC_W (16),
        .POLY  (16'h1021),
        .LANES (4)
    ) u16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear16),
        .enable    (en16),
        .in_bits   (bits16),
        .start_out (start16),
        .crc       (crc16),
        .out_bits  (out_bits16),
        .out_valid (out_valid16),
        .out_last  (out_last16),
        .busy      (busy16),
        .crc_ok    (crc_ok16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed7(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            en7   = 1'b1;
            bits7 = v[i];
            tick();
        end
        en7 = 1'b0;
    endtask

    task automatic push7(input logic [6:0] v);
        for (int i = 6; i >= 0; i--) begin
            q7.push_back('{bits: {3'b000, v[i]}, last: (i == 0)});
        end
    endtask

    task automatic push16(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            q16.push_back('{bits: {4{v[i]}}, last: (i == 0)});
        end
    endtask

    task automatic clear_7();
        clear7 = 1'b1;
        tick();
        clear7 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid7) begin
            if (q7.size() == 0) begin
                check("unexpected_valid7", out_valid7, 0);
            end else begin
                m7_e = q7.pop_front();
                check("out_bits7", out_bits7, m7_e.bits);
                check("out_last7", out_last7, m7_e.last);
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid16) begin
            if (q16.size() == 0) begin
                check("unexpected_valid16", out_valid16, 0);
            end else begin
                m16_e = q16.pop_front();
                check("out_bits16", out_bits16, m16_e.bits);
                check("out_last16", out_last16, m16_e.last);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clear7 = 0; en7 = 0; start7 = 0; bits7 = 0;
        clear16 = 0; en16 = 0; start16 = 0; bits16 = 0;
        #2;
        check("rst_crc7", crc7, 0);
        check("rst_crc_ok7", crc_ok7, 1);
        check("rst_out_bits7", out_bits7, 0);
        check("rst_valid7", out_valid7, 0);
        check("rst_last7", out_last7, 0);
        check("rst_busy7", busy7, 0);
        check("rst_crc16", crc16, 0);
        check("rst_crc_ok16", crc_ok16, 1);
        check("rst_out_bits16", out_bits16, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // CMD0 accumulate and shift-out
        feed7(64'h40_0000_0000, 40);
        check("cmd0_crc", crc7, 7'h4A);
        start7 = 1'b1;
        push7(7'h4A);
        tick();
        start7 = 1'b0;
        repeat (7) tick();
        check("cmd0_after_crc", crc7, 0);
        check("cmd0_after_busy", busy7, 0);
        check("cmd0_after_valid", out_valid7, 0);

        // CMD8 generate, then check mode with good and corrupted payload
        clear_7();
        feed7(64'h48_0000_01AA, 40);
        check("cmd8_crc", crc7, 7'h43);
        feed7(64'h43, 7);
        check("cmd8_check_ok", crc_ok7, 1);
        check("cmd8_check_crc", crc7, 0);
        clear_7();
        feed7(64'h48_0000_01AB, 40);
        feed7(64'h43, 7);
        check("cmd8_flip_ok", crc_ok7, 0);

        // clear on the third shift cycle
        clear_7();
        feed7(64'h40_0000_0000, 40);
        q7.push_back('{bits: 4'd1, last: 1'b0});
        q7.push_back('{bits: 4'd0, last: 1'b0});
        q7.push_back('{bits: 4'd0, last: 1'b0});
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        repeat (2) tick();
        clear7 = 1'b1;
        tick();
        clear7 = 1'b0;
        check("clr_valid", out_valid7, 0);
        check("clr_busy", busy7, 0);
        check("clr_crc", crc7, 0);

        // async reset mid-accumulate
        feed7(64'h40_12, 16);
        reset_n = 1'b0;
        #1;
        check("rsta_crc", crc7, 0);
        check("rsta_ok", crc_ok7, 1);
        check("rsta_busy", busy7, 0);
        #2 reset_n = 1'b1;
        tick();

        // async reset mid-shift: only the first bit gets out
        feed7(64'h40_0000_0000, 40);
        q7.push_back('{bits: 4'd1, last: 1'b0});
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("rsts_valid", out_valid7, 0);
        check("rsts_last", out_last7, 0);
        check("rsts_busy", busy7, 0);
        check("rsts_crc", crc7, 0);
        check("rsts_out_bits", out_bits7, 0);
        #2 reset_n = 1'b1;
        tick();

        // start_out held two cycles with enable high, then re-armed in first ACCUM cycle
        feed7(64'h40_0000_0000, 40);
        en7 = 1'b1;
        bits7 = 1'b1;
        start7 = 1'b1;
        push7(7'h4A);
        tick();
        tick();
        start7 = 1'b0;
        en7 = 1'b0;
        repeat (6) tick();
        check("hold_first_accum_busy", busy7, 0);
        start7 = 1'b1;
        push7(7'h00);
        tick();
        start7 = 1'b0;
        repeat (7) tick();
        check("hold_end_busy", busy7, 0);
        check("hold_end_crc", crc7, 0);

        // CRC16, four lanes, 512 bytes of 0xFF
        bits16 = 4'hF;
        en16 = 1'b1;
        repeat (4096) tick();
        en16 = 1'b0;
        check("crc16_val", crc16, {4{16'h7FA1}});
        check("crc16_ok_pre", crc_ok16, 0);
        start16 = 1'b1;
        push16(16'h7FA1);
        tick();
        start16 = 1'b0;
        repeat (16) tick();
        check("crc16_ok_post", crc_ok16, 1);
        check("crc16_busy_post", busy16, 0);

        repeat (3) tick();
        check("q7_drained", q7.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
